// File: rtl/equiv_pkg.sv
// Shared types and defaults for the stream equivalence miter.
package equiv_pkg;

    // Monitor state; encodings are visible on the state output port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FAIL = 2'd2,
        ST_OVF  = 2'd3
    } equiv_state_e;

    localparam int unsigned EQUIV_CNT_W = 16;

endpackage

// File: rtl/equiv_skew_fifo.sv
// Small skew-absorbing FIFO; pointers carry one extra wrap bit for full/empty.
module equiv_skew_fifo #(
    parameter int unsigned WIDTH = 91,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointers and storage; a push into a full FIFO is accepted only alongside a pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push && (!full || pop)) begin
                mem_d[wr_ptr_q[AW-1:0]] = din;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    // Pointer and storage registers; storage contents need no reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/equiv_stream_miter.sv
// Equivalence monitor comparing two skewed output streams through per-side FIFOs.
module equiv_stream_miter
    import equiv_pkg::*;
#(
    parameter int unsigned WIDTH         = 91,
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned CNT_W         = EQUIV_CNT_W,
    parameter bit          STOP_ON_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic [1:0]       state,
    output logic             fail,
    output logic             ovf,
    output logic [CNT_W-1:0] cmp_count,
    output logic [CNT_W-1:0] mis_count,
    output logic [CNT_W-1:0] first_idx,
    output logic [WIDTH-1:0] first_diff
);

    equiv_state_e     state_q, state_d;
    logic             fail_q, fail_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cmp_count_q, cmp_count_d;
    logic [CNT_W-1:0] mis_count_q, mis_count_d;
    logic [CNT_W-1:0] first_idx_q, first_idx_d;
    logic [WIDTH-1:0] first_diff_q, first_diff_d;

    logic             flush, run_act, do_cmp, heads_differ;
    logic             a_push, a_ovf, a_empty, a_full;
    logic             b_push, b_ovf, b_empty, b_full;
    logic [WIDTH-1:0] a_dout, b_dout;

    equiv_skew_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (a_push),
        .pop   (do_cmp),
        .din   (a_data),
        .dout  (a_dout),
        .empty (a_empty),
        .full  (a_full)
    );

    equiv_skew_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (b_push),
        .pop   (do_cmp),
        .din   (b_data),
        .dout  (b_dout),
        .empty (b_empty),
        .full  (b_full)
    );

    // Datapath control: pops only in RUN with both heads present; overflow means full with no pop.
    always_comb begin
        run_act      = en && (state_q == ST_RUN);
        do_cmp       = run_act && !a_empty && !b_empty;
        a_ovf        = run_act && a_valid && a_full && !do_cmp;
        b_ovf        = run_act && b_valid && b_full && !do_cmp;
        a_push       = run_act && a_valid && !a_ovf;
        b_push       = run_act && b_valid && !b_ovf;
        heads_differ = (a_dout != b_dout);
        flush        = !en || (state_q == ST_IDLE);
    end

    // FSM, saturating counters and first-mismatch capture.
    always_comb begin
        state_d      = state_q;
        fail_d       = fail_q;
        ovf_d        = ovf_q;
        cmp_count_d  = cmp_count_q;
        mis_count_d  = mis_count_q;
        first_idx_d  = first_idx_q;
        first_diff_d = first_diff_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d      = ST_RUN;
                    fail_d       = 1'b0;
                    ovf_d        = 1'b0;
                    cmp_count_d  = '0;
                    mis_count_d  = '0;
                    first_idx_d  = '0;
                    first_diff_d = '0;
                end
                ST_RUN: begin
                    if (do_cmp) begin
                        if (cmp_count_q != '1) cmp_count_d = cmp_count_q + CNT_W'(1);
                        if (heads_differ) begin
                            if (mis_count_q != '1) mis_count_d = mis_count_q + CNT_W'(1);
                            if (!fail_q) begin
                                first_idx_d  = cmp_count_q;
                                first_diff_d = a_dout ^ b_dout;
                            end
                            fail_d = 1'b1;
                        end
                    end
                    // Overflow wins over a same-cycle mismatch for the next state only.
                    if (a_ovf || b_ovf) begin
                        ovf_d   = 1'b1;
                        state_d = ST_OVF;
                    end else if (do_cmp && heads_differ && STOP_ON_FIRST) begin
                        state_d = ST_FAIL;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Monitor registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            fail_q       <= 1'b0;
            ovf_q        <= 1'b0;
            cmp_count_q  <= '0;
            mis_count_q  <= '0;
            first_idx_q  <= '0;
            first_diff_q <= '0;
        end else begin
            state_q      <= state_d;
            fail_q       <= fail_d;
            ovf_q        <= ovf_d;
            cmp_count_q  <= cmp_count_d;
            mis_count_q  <= mis_count_d;
            first_idx_q  <= first_idx_d;
            first_diff_q <= first_diff_d;
        end
    end

    assign state      = state_q;
    assign fail       = fail_q;
    assign ovf        = ovf_q;
    assign cmp_count  = cmp_count_q;
    assign mis_count  = mis_count_q;
    assign first_idx  = first_idx_q;
    assign first_diff = first_diff_q;

endmodule

// File: doc/equiv_stream_miter.md
# equiv_stream_miter

Parametrised equivalence monitor for the fuzz/equivalence harnesses: compares the output streams of two implementations of the same design (for example pre- and post-synthesis) that may emit results with different, bounded latencies. Each side's outputs are buffered in a small skew FIFO. Heads are compared in order, and the block keeps compare and mismatch counts, a sticky fail flag, and a capture of the first mismatch. It sits beside the two DUT instances in a harness top and replaces the per-cycle `y_1 == y_2` check, which only holds for lock-step, single-width outputs.

## Interface
- `WIDTH`, 91: width of each compared output word.
- `DEPTH`, 8: entries per skew FIFO, power of two, ≥2. This is the maximum tolerated latency skew in samples.
- `CNT_W`, 16: width of all counters and indices.
- `STOP_ON_FIRST`, 1: 1 = freeze on first mismatch; 0 = keep comparing and counting.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en`  in  1  arm; low = idle and flush.
- `a_valid`  in  1  side-A sample strobe.
- `a_data`  in  WIDTH  side-A output word.
- `b_valid`  in  1  side-B sample strobe.
- `b_data`  in  WIDTH  side-B output word.
- `state`  out  2  IDLE=0, RUN=1, FAIL=2, OVF=3.
- `fail`  out  1  sticky: at least one mismatch since arm.
- `ovf`  out  1  sticky: push into a full FIFO since arm.
- `cmp_count`  out  CNT_W  compares performed, saturating.
- `mis_count`  out  CNT_W  mismatches, saturating.
- `first_idx`  out  CNT_W  value of `cmp_count` before the first mismatching compare.
- `first_diff`  out  WIDTH  `a ^ b` of the first mismatching pair.

## Operation
- Reset (`rst_n`=0 at an edge): state=IDLE. Both FIFOs are emptied. All outputs are 0.
- IDLE:
  - FIFOs are held empty and pushes are ignored. Counters and captures keep their values.
  - `en`=1 → RUN. On that transition, counters, `fail`, `ovf`, `first_idx` and `first_diff` clear to 0.
- RUN:
  - `a_valid` pushes `a_data` into FIFO A; `b_valid` pushes `b_data` into FIFO B.
  - When both FIFOs are non-empty, both heads pop and one compare is performed. `cmp_count` increments.
  - If the heads differ, `mis_count` increments and `fail` is set.
  - On the first mismatch only, `first_idx` and `first_diff` are captured.
  - After a mismatch: with `STOP_ON_FIRST`=1 → FAIL; otherwise the block stays in RUN.
- FAIL:
  - No pops and no pushes. Counters and captures are frozen.
- OVF:
  - Entered from RUN when a push hits a full FIFO. The offending sample is dropped and `ovf` is set.
  - No further compares. Counters are frozen.
- Every state returns to IDLE when `en`=0, flushing both FIFOs. FAIL and OVF are left only this way or by reset.
- A push to a full FIFO in the same cycle as a pop of that FIFO is legal and is not an overflow.
- Overflow takes priority over a mismatch in the same cycle: the next state is OVF, `fail` is still set, and the mismatch is captured.
- Both counters saturate at 2^CNT_W−1. Saturation does not affect `fail`.

## Timing
- A word pushed at edge t is a FIFO head after edge t.
- A compare uses the heads present before edge t+1. Its results (counters, flags, captures, state) are visible after edge t+1.
- Minimum push-to-result latency is 2 edges. There is no bypass path.
- Throughput is one compare per cycle.
- `en`=0 and `rst_n`=0 act at the same edge. `rst_n` dominates.
- Reset asserted mid-stream discards all buffered samples.

## Structure
- Package `equiv_pkg`: state enum `equiv_state_e` (IDLE, RUN, FAIL, OVF) and default constant `EQUIV_CNT_W`=16.
- Sub-module `equiv_skew_fifo`, instantiated twice:
  - parameters WIDTH and DEPTH;
  - ports push, pop, din, dout, empty, full, flush;
  - registered storage with pointers one bit wider than log2(DEPTH) for full/empty.
- The top holds the FSM, compare, counters and capture registers.

## Test plan
- Lock-step identical streams: 10 pairs with a and b both equal to 0..9 → `cmp_count`=10, `mis_count`=0, `fail`=0, state=RUN.
- Skew: B delayed 5 cycles from A, 20 identical samples, DEPTH=8 → 20 compares, no `ovf`, `fail`=0.
- Mismatch: the 4th pair differs in bit 90 → `fail`=1, `first_idx`=3, `first_diff`=1<<90.
  - STOP_ON_FIRST=1: state=FAIL, `cmp_count`=4.
  - STOP_ON_FIRST=0: later pairs continue counting.
- Overflow: 9 A pushes with no B, DEPTH=8 → state=OVF, `ovf`=1, `cmp_count`=0.
- Re-arm and reset:
  - drop `en` in FAIL, then raise it → all counters 0 and state=RUN;
  - assert `rst_n`=0 mid-stream → all outputs 0 and state=IDLE on the next edge.
